// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream round-robin FIFO arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_SRC = 4;
  localparam int unsigned DEF_DATA_W  = 8;

  // A single requester still needs a one-bit index.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request after last_grant, wrapping modulo NUM_SRC.
module rr_pick #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               any_req,
  output logic [ID_W-1:0]    win_id
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest candidate down so the nearest one is written last and wins.
  always_comb begin
    any_req = |req;
    win_id  = '0;
    idx     = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_SRC);
      if (req[idx]) begin
        win_id = idx;
      end
    end
  end

endmodule

// File: rtl/axis_fifo_rr_arbiter.sv
// Packet-level round-robin arbiter feeding one FIFO write port through a registered output stage.
module axis_fifo_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ID_W    = id_width(NUM_SRC),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [ID_W-1:0]           m_axis_tid,
  input  logic                      m_axis_tready,
  output logic                      busy,
  output logic [CNT_W-1:0]          pkt_cnt
);

  arb_state_e        state;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   win_id;
  logic              any_req;
  logic              load_ok;
  logic              in_hs;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .win_id     (win_id)
  );

  // Output register can take a new beat when empty or draining this cycle.
  always_comb begin
    load_ok       = (state == XFER) && (!m_axis_tvalid || m_axis_tready);
    sel_data      = '0;
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_data         = s_axis_tdata[i*DATA_W +: DATA_W];
        sel_valid        = s_axis_tvalid[i];
        sel_last         = s_axis_tlast[i];
        s_axis_tready[i] = load_ok;
      end
    end
    in_hs = load_ok && sel_valid;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= ARB;
      busy          <= 1'b0;
      grant_id      <= '0;
      last_grant    <= ID_W'(NUM_SRC - 1);
      pkt_cnt       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else begin
      unique case (state)
        ARB: begin
          if (any_req) begin
            grant_id <= win_id;
            state    <= XFER;
            busy     <= 1'b1;
          end
        end
        XFER: begin
          if (in_hs && sel_last) begin
            last_grant <= grant_id;
            pkt_cnt    <= pkt_cnt + CNT_W'(1);
            state      <= ARB;
            busy       <= 1'b0;
          end
        end
        default: state <= ARB;
      endcase

      if (in_hs) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= sel_last;
        m_axis_tid    <= grant_id;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
// Randomized bench: per-source packet queues, a round-robin grant model and an output scoreboard.
module tb_axis_fifo_rr_arbiter;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 4;

  logic                      aclk = 1'b0;
  logic                      areset;
  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tlast;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tlast;
  logic [ID_W-1:0]           m_axis_tid;
  logic                      m_axis_tready;
  logic                      busy;
  logic [CNT_W-1:0]          pkt_cnt;

  always #5 aclk = ~aclk;

  axis_fifo_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Source beats are {last, data}; scoreboard entries are {last, id, data}.
  logic [DATA_W:0]      srcq [NUM_SRC][$];
  logic [ID_W+DATA_W:0] sb [$];
  logic [NUM_SRC-1:0]   vld;
  bit                   m_busy;
  int                   m_grant;
  int                   m_last;
  int                   m_cnt;
  int unsigned          vprob;
  int unsigned          rprob;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_grant = 0;
    m_last  = NUM_SRC - 1;
    m_cnt   = 0;
    sb.delete();
  endtask

  task automatic add_pkt(input int s, input int len);
    for (int k = 0; k < len; k++) srcq[s].push_back({1'(k == len - 1), DATA_W'($urandom)});
  endtask

  function automatic bit idle();
    bit r = !m_busy && (sb.size() == 0) && (vld == '0);
    for (int i = 0; i < NUM_SRC; i++) if (srcq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  // Entered just after a rising edge; drives, checks at the falling edge, advances the model.
  task automatic step();
    logic [NUM_SRC-1:0]   exp_rdy;
    logic [DATA_W:0]      beat;
    logic [ID_W+DATA_W:0] ent;
    int                   w;
    int                   idx;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!vld[i] && srcq[i].size() != 0 && $urandom_range(99) < vprob) vld[i] = 1'b1;
      beat = vld[i] ? srcq[i][0] : (DATA_W + 1)'($urandom);
      s_axis_tvalid[i] = vld[i];
      s_axis_tlast[i]  = beat[DATA_W];
      s_axis_tdata[i*DATA_W +: DATA_W] = beat[DATA_W-1:0];
    end
    m_axis_tready = ($urandom_range(99) < rprob);
    @(negedge aclk);
    for (int i = 0; i < NUM_SRC; i++)
      exp_rdy[i] = m_busy && (i == m_grant) && (sb.size() == 0 || m_axis_tready);
    check("busy", 32'(busy), 32'(m_busy));
    check("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
    check("m_tvalid", 32'(m_axis_tvalid), 32'(sb.size() != 0));
    check("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
    if (sb.size() != 0) begin
      ent = sb[0];
      check("m_tdata", 32'(m_axis_tdata), 32'(ent[DATA_W-1:0]));
      check("m_tid", 32'(m_axis_tid), 32'(ent[DATA_W+ID_W-1:DATA_W]));
      check("m_tlast", 32'(m_axis_tlast), 32'(ent[DATA_W+ID_W]));
      if (m_axis_tready) void'(sb.pop_front());
    end
    if (m_busy) begin
      if (exp_rdy[m_grant] && vld[m_grant]) begin
        beat = srcq[m_grant].pop_front();
        vld[m_grant] = 1'b0;
        sb.push_back({beat[DATA_W], ID_W'(m_grant), beat[DATA_W-1:0]});
        if (beat[DATA_W]) begin
          m_busy = 1'b0;
          m_last = m_grant;
          m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        end
      end
    end else begin
      w = -1;
      for (int k = 1; k <= NUM_SRC; k++) begin
        idx = (m_last + k) % NUM_SRC;
        if (vld[idx]) begin
          w = idx;
          break;
        end
      end
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_grant = w;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic run_idle(input int max_cyc);
    int n = 0;
    while (!idle() && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_done", 32'(idle()), 32'd1);
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
    vld           = '0;
    vprob         = 100;
    rprob         = 100;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_m_tid", 32'(m_axis_tid), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    areset = 1'b0;

    // Single source, three beats.
    srcq[0].push_back({1'b0, 8'h10});
    srcq[0].push_back({1'b0, 8'h11});
    srcq[0].push_back({1'b1, 8'h12});
    run_idle(50);
    check("pkt_cnt_single", 32'(pkt_cnt), 32'd1);

    // All sources with continuous 2-beat packets.
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NUM_SRC; s++) add_pkt(s, 2);
    run_idle(200);
    check("pkt_cnt_after_8", 32'(pkt_cnt), 32'd9);

    // Random traffic with source gaps and FIFO backpressure.
    vprob = 40;
    rprob = 60;
    repeat (600) begin
      for (int s = 0; s < NUM_SRC; s++)
        if (srcq[s].size() == 0 && $urandom_range(3) == 0) add_pkt(s, $urandom_range(1, 4));
      step();
    end
    run_idle(600);

    // Async reset while a beat sits stalled in the output register.
    vprob = 100;
    rprob = 0;
    add_pkt(1, 4);
    repeat (3) step();
    check("pre_rst_m_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    areset = 1'b1;
    #1;
    check("async_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_s_tready", 32'(s_axis_tready), 32'd0);
    check("async_pkt_cnt", 32'(pkt_cnt), 32'd0);
    model_reset();
    for (int s = 0; s < NUM_SRC; s++) srcq[s].delete();
    vld           = '0;
    s_axis_tvalid = '0;
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Counter wrap: 17 single-beat packets; src1 must win first after reset.
    rprob = 100;
    add_pkt(1, 1);
    for (int p = 0; p < 16; p++) add_pkt(3, 1);
    run_idle(200);
    check("pkt_cnt_wrap", 32'(pkt_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_fifo_rr_arbiter.md
Name: axis_fifo_rr_arbiter

Overview:
Packet-level round-robin arbiter that shares one AXI_FIFO_4096 write port among NUM_SRC AXI-Stream sources.
- Grants one source at a time and holds the grant until that source's tlast beat is accepted.
- Forwards beats through a single registered output stage into the FIFO slave port, tagging each beat with the granted source index.
- Sits directly in front of the FIFO. FIFO backpressure arrives on m_axis_tready.

Parameters:
- NUM_SRC, 4, number of AXIS requesters (2..8).
- DATA_W, 8, tdata width; matches the FIFO data width.
- ID_W, 2, source index width; equals clog2(NUM_SRC), minimum 1.
- CNT_W, 16, width of the accepted-packet counter.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_SRC*DATA_W  packed source data; source i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source last.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  DATA_W  to FIFO s_axis_tdata.
- m_axis_tvalid  out  1  to FIFO s_axis_tvalid.
- m_axis_tlast  out  1  to FIFO s_axis_tlast.
- m_axis_tid  out  ID_W  source index of the current output beat.
- m_axis_tready  in  1  from FIFO s_axis_tready.
- busy  out  1  high while a grant is held.
- pkt_cnt  out  CNT_W  count of packets whose tlast was accepted at the input.

Behaviour:
Reset values (all asynchronous):
- state=ARB, busy=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, pkt_cnt=0.
- last_grant=NUM_SRC-1, so source 0 wins the first arbitration.

FSM, two states:
- ARB:
  - All s_axis_tready are 0.
  - If any tvalid is high, the winner is the first asserted index scanning last_grant+1, last_grant+2, ... modulo NUM_SRC.
  - Register grant_id, go to XFER, and set busy on the next edge.
  - If no tvalid is high, stay in ARB.
- XFER:
  - s_axis_tready[grant_id] = (!m_axis_tvalid || m_axis_tready). This is combinational from registered state and m_axis_tready.
  - All other ready bits are 0.
  - On an input handshake, register tdata, tlast and grant_id into the output stage and set m_axis_tvalid.
  - On a handshake with tlast=1: last_grant<=grant_id, pkt_cnt+1, state->ARB, busy->0.

Output stage:
- m_axis_tvalid clears when m_axis_tready=1 and no new input handshake occurs in the same cycle.
- A simultaneous output drain and input load keeps tvalid=1 with the new beat, giving full throughput.
- m_axis_tdata, tlast and tid are stable while tvalid=1 and tready=0 (AXIS rule).

Latency:
- First beat of a packet is accepted at earliest 1 cycle after its tvalid rises in ARB.
- Input to output is 1 cycle.
- There is exactly one ARB bubble cycle between packets, including back-to-back packets from the same source.

Boundary conditions:
- FIFO full (m_axis_tready=0 while the output register holds a beat): the granted ready drops. No beat is lost or duplicated.
- Granted source drops tvalid mid-packet: the grant is held indefinitely with no timeout. Other sources wait.
- Single-beat packet (tvalid and tlast on the first beat): behaves as a normal packet. One ARB cycle follows.
- Only one requester active: it is re-granted every packet.
- pkt_cnt wraps from 2^CNT_W-1 to 0.
- Reset mid-packet: the output beat is discarded, the grant is dropped, and round-robin restarts at source 0. A partial packet already in the FIFO is not recalled.

Decomposition:
- Package axis_arb_pkg holds:
  - state encoding (ARB=1'b0, XFER=1'b1)
  - the clog2-based ID width function
  - the default DATA_W and NUM_SRC constants.
- Sub-module rr_pick: purely combinational. Inputs are the req vector and last_grant. Outputs are any_req and win_id. It is instantiated once.

Test Plan:
- Reset then a single source: src0 sends 3 beats 0x10,0x11,0x12 with tlast on 0x12, m_axis_tready=1 -> out tdata 0x10,0x11,0x12, tid=0, tlast on the third beat; pkt_cnt=1; first output beat appears 2 cycles after tvalid rises.
- All 4 sources hold 2-beat packets continuously, tready=1 -> grant order 0,1,2,3,0,...; one bubble between packets; pkt_cnt=8 after 8 packets.
- Backpressure: m_axis_tready=0 for 5 cycles mid-packet with src2 granted -> output beat held stable; s_axis_tready[2]=0; no beat dropped or repeated after release.
- Lock on tlast: src1 is granted, src0 asserts tvalid mid-packet -> src0's ready stays 0 until src1's tlast handshakes; src0 wins the next arbitration.
- Async reset asserted mid-packet for 1 cycle -> m_axis_tvalid=0 and busy=0 immediately without a clock edge; the next grant goes to the lowest-index requester.
- Counter wrap with CNT_W=4 -> after 17 single-beat packets, pkt_cnt=1.
